// File: rtl/sing_wire_pkg.sv
// Shared types and frame constants for the single-wire transceiver.
// Also provides a helper for the total frame length in clock cycles.
package sing_wire_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TX,
    TURN,
    RX
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Cycles the line is driven for one complete frame: start + data + stop bits.
  function automatic int unsigned frame_cycles(input int unsigned data_w,
                                               input int unsigned bit_cyc);
    return (data_w + 2) * bit_cyc;
  endfunction

endpackage

// File: rtl/sing_wire_sync.sv
// Two-flop synchronizer for the pad input plus falling-edge detector.
// Every flop resets to the idle (pulled-up) level so reset never produces a false edge.
module sing_wire_sync
  import sing_wire_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic ps,
  output logic fall
);

  logic meta_q;
  logic ps_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= IDLE_LEVEL;
      ps_q   <= IDLE_LEVEL;
      prev_q <= IDLE_LEVEL;
    end else begin
      meta_q <= din;
      ps_q   <= meta_q;
      prev_q <= ps_q;
    end
  end

  assign ps   = ps_q;
  assign fall = prev_q & ~ps_q;

endmodule

// File: rtl/sing_wire_xcvr.sv
// Half-duplex single-wire bit-serial transceiver driving an IOBUF (pad_o/pad_t/pad_i).
// TX has collision detection and a fixed release period; RX is started by a falling edge.
module sing_wire_xcvr
  import sing_wire_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned BIT_CYC  = 4,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_col,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_err,
  output logic              pad_o,
  output logic              pad_t,
  input  logic              pad_i
);

  localparam int unsigned CW = $clog2(BIT_CYC);
  localparam int unsigned BW = $clog2(DATA_W + 2);
  localparam int unsigned TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  localparam logic [CW-1:0] CycLast  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] CycMid   = CW'(BIT_CYC / 2 - 1);
  localparam logic [BW-1:0] BitStop  = BW'(DATA_W + 1);
  localparam logic [BW-1:0] BitLastD = BW'(DATA_W);
  localparam logic [TW-1:0] TurnLast = TW'(TURN_CYC - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [TW-1:0]     turn_q, turn_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              pad_o_q, pad_o_d;
  logic              pad_t_q, pad_t_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_err_q, rx_err_d;
  logic              rx_done_q, rx_done_d;

  logic ps;
  logic fall;
  logic accept;
  logic cyc_end;
  logic col;

  sing_wire_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pad_i),
    .ps   (ps),
    .fall (fall)
  );

  // A falling edge in IDLE takes priority over a pending TX byte.
  assign tx_ready = (state_q == IDLE) && !fall && !rst;
  assign accept   = tx_valid && tx_ready;
  assign cyc_end  = (cyc_q == CycLast);
  // Checked at the last cycle of a bit so the synchronizer has caught up with the line.
  assign col      = (state_q == TX) && cyc_end && pad_o_q && !ps;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    turn_d     = turn_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    pad_o_d    = pad_o_q;
    pad_t_d    = pad_t_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    rx_done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = TX;
          shreg_d = tx_data;
          cyc_d   = '0;
          bit_d   = '0;
          pad_t_d = 1'b0;
          pad_o_d = START_BIT;
        end else if (fall) begin
          state_d = RX;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end

      TX: begin
        cyc_d = cyc_end ? '0 : cyc_q + CW'(1);
        if (cyc_end) begin
          if (col || (bit_q == BitStop)) begin
            state_d = TURN;
            turn_d  = '0;
            pad_t_d = 1'b1;
            pad_o_d = IDLE_LEVEL;
          end else begin
            bit_d = bit_q + BW'(1);
            if (bit_q == BitLastD) begin
              pad_o_d = STOP_BIT;
            end else begin
              pad_o_d = shreg_q[0];
              shreg_d = shreg_q >> 1;
            end
          end
        end
      end

      TURN: begin
        if (turn_q == TurnLast) begin
          state_d = IDLE;
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end

      RX: begin
        // One extra cycle after the stop sample keeps an accept out of the pulse cycle.
        if (rx_done_q) begin
          state_d = IDLE;
        end else begin
          cyc_d = cyc_end ? '0 : cyc_q + CW'(1);
          if (cyc_end) begin
            bit_d = bit_q + BW'(1);
          end
          if (cyc_q == CycMid) begin
            if (bit_q == '0) begin
              if (ps != START_BIT) begin
                state_d = IDLE;
              end
            end else if (bit_q == BitStop) begin
              rx_done_d = 1'b1;
              if (ps == STOP_BIT) begin
                rx_valid_d = 1'b1;
                rx_data_d  = shreg_q;
              end else begin
                rx_err_d = 1'b1;
              end
            end else begin
              shreg_d = DATA_W'({ps, shreg_q} >> 1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      turn_q     <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      pad_o_q    <= IDLE_LEVEL;
      pad_t_q    <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      turn_q     <= turn_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      pad_o_q    <= pad_o_d;
      pad_t_q    <= pad_t_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      rx_done_q  <= rx_done_d;
    end
  end

  assign tx_col   = col && !rst;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign rx_data  = rx_data_q;
  assign pad_o    = pad_o_q;
  assign pad_t    = pad_t_q;

endmodule

// File: tb/tb_sing_wire_xcvr.sv
// Directed bench for sing_wire_xcvr: models the IOBUF with a pull-up and an external driver
// that pulls the line low (low wins on contention).
module tb_sing_wire_xcvr;
  import sing_wire_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_col;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       pad_o;
  logic       pad_t;
  logic       pad_i;
  logic       ext_en;
  logic       ext_val;

  int n_chk = 0;
  int n_err = 0;

  // Observation counters, written only by the monitor below.
  int cyc_n    = 0;
  int cnt_rv   = 0;
  int cnt_re   = 0;
  int cnt_col  = 0;
  int cnt_tlow = 0;
  int cnt_acc  = 0;
  int rv_cyc   = 0;
  int acc_cyc  = 0;

  always #5 clk = ~clk;

  assign pad_i = ~((~pad_t & ~pad_o) | (ext_en & ~ext_val));

  sing_wire_xcvr #(
    .DATA_W   (8),
    .BIT_CYC  (4),
    .TURN_CYC (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_col   (tx_col),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_err   (rx_err),
    .pad_o    (pad_o),
    .pad_t    (pad_t),
    .pad_i    (pad_i)
  );

  always @(negedge clk) begin
    cyc_n <= cyc_n + 1;
    if (rx_valid) begin
      cnt_rv <= cnt_rv + 1;
      rv_cyc <= cyc_n;
    end
    if (rx_err) cnt_re <= cnt_re + 1;
    if (tx_col) cnt_col <= cnt_col + 1;
    if (!pad_t) cnt_tlow <= cnt_tlow + 1;
    if (tx_valid && tx_ready) begin
      cnt_acc <= cnt_acc + 1;
      acc_cyc <= cyc_n;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_ext(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      ext_en  = 1'b1;
      ext_val = f[b];
      tick(4);
    end
    ext_en  = 1'b0;
    ext_val = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         n;
    int         k;
    int         rv0, re0, col0, tl0, acc0;
    logic [63:0] got;
    logic [63:0] expv;
    logic [9:0]  frame;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    ext_en   = 1'b0;
    ext_val  = 1'b1;
    tick(3);

    // Reset state
    check("rst_pad_t", 64'(pad_t), 64'(1));
    check("rst_pad_o", 64'(pad_o), 64'(1));
    check("rst_tx_col", 64'(tx_col), 64'(0));
    check("rst_rx_valid", 64'(rx_valid), 64'(0));
    check("rst_rx_err", 64'(rx_err), 64'(0));
    check("rst_rx_data", 64'(rx_data), 64'(0));
    check("rst_ready", 64'(tx_ready), 64'(0));
    rst = 1'b0;
    #1;
    check("idle_ready", 64'(tx_ready), 64'(1));
    tick(2);

    // TX 8'hA5, no external driver
    col0     = cnt_col;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    #1;
    check("tx_acc_ready", 64'(tx_ready), 64'(1));
    tick(1);
    tx_valid = 1'b0;
    n   = 0;
    got = '0;
    while (pad_t == 1'b0 && n < 60) begin
      got[n] = pad_o;
      n++;
      tick(1);
    end
    frame = {1'b1, 8'hA5, 1'b0};
    expv  = '0;
    for (int i = 0; i < 40; i++) expv[i] = frame[i/4];
    check("tx_cycles", 64'(n), 64'(frame_cycles(8, 4)));
    check("tx_bits", got, expv);
    check("tx_turn0_ready", 64'(tx_ready), 64'(0));
    tick(1);
    check("tx_turn1_pad_t", 64'(pad_t), 64'(1));
    check("tx_turn1_ready", 64'(tx_ready), 64'(0));
    tick(1);
    check("tx_idle_ready", 64'(tx_ready), 64'(1));
    check("tx_no_col", 64'(cnt_col - col0), 64'(0));

    // External frame 8'h3C
    rv0 = cnt_rv; re0 = cnt_re; tl0 = cnt_tlow;
    send_ext(8'h3C, 1'b1);
    tick(4);
    check("rx_valid_cnt", 64'(cnt_rv - rv0), 64'(1));
    check("rx_data_3c", 64'(rx_data), 64'(8'h3C));
    check("rx_err_cnt", 64'(cnt_re - re0), 64'(0));
    check("rx_pad_t_held", 64'(cnt_tlow - tl0), 64'(0));

    // Two-cycle low glitch on idle line
    rv0 = cnt_rv; re0 = cnt_re;
    ext_en  = 1'b1;
    ext_val = 1'b0;
    tick(2);
    ext_en  = 1'b0;
    ext_val = 1'b1;
    k = 0;
    while (!tx_ready && k < 10) begin
      tick(1);
      k++;
    end
    check("glitch_ready_lat", 64'(k <= 4), 64'(1));
    tick(2);
    check("glitch_no_rv", 64'(cnt_rv - rv0), 64'(0));
    check("glitch_no_err", 64'(cnt_re - re0), 64'(0));

    // External frame with bad stop bit
    rv0 = cnt_rv; re0 = cnt_re;
    send_ext(8'h81, 1'b0);
    tick(4);
    check("stop0_err_cnt", 64'(cnt_re - re0), 64'(1));
    check("stop0_no_rv", 64'(cnt_rv - rv0), 64'(0));
    check("stop0_data_kept", 64'(rx_data), 64'(8'h3C));

    // Collision during a '1' data bit of 8'hFF
    col0     = cnt_col;
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(4);
    ext_en  = 1'b1;
    ext_val = 1'b0;
    k = 0;
    while (!tx_col && k < 20) begin
      tick(1);
      k++;
    end
    check("col_pulse", 64'(tx_col), 64'(1));
    tick(1);
    ext_en  = 1'b0;
    ext_val = 1'b1;
    check("col_pad_t", 64'(pad_t), 64'(1));
    check("col_pad_o", 64'(pad_o), 64'(1));
    check("col_turn0_ready", 64'(tx_ready), 64'(0));
    tick(1);
    check("col_turn1_pad_t", 64'(pad_t), 64'(1));
    check("col_turn1_ready", 64'(tx_ready), 64'(0));
    tick(1);
    check("col_idle_ready", 64'(tx_ready), 64'(1));
    check("col_cnt", 64'(cnt_col - col0), 64'(1));

    // tx_valid coincides with an external falling edge
    rv0 = cnt_rv; acc0 = cnt_acc;
    fork
      send_ext(8'h5A, 1'b1);
      begin
        tick(2);
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        #1;
        check("rx_wins_ready", 64'(tx_ready), 64'(0));
        k = 0;
        while (!tx_ready && k < 80) begin
          tick(1);
          k++;
        end
        tick(1);
        tx_valid = 1'b0;
      end
    join
    k = 0;
    while (!tx_ready && k < 100) begin
      tick(1);
      k++;
    end
    check("race_rv_cnt", 64'(cnt_rv - rv0), 64'(1));
    check("race_rx_data", 64'(rx_data), 64'(8'h5A));
    check("race_acc_cnt", 64'(cnt_acc - acc0), 64'(1));
    check("race_acc_after_rv", 64'(acc_cyc - rv_cyc), 64'(1));

    // Reset pulse mid-TX
    col0     = cnt_col;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(10);
    check("midtx_driving", 64'(pad_t), 64'(0));
    rst = 1'b1;
    tick(1);
    check("rstx_pad_t", 64'(pad_t), 64'(1));
    check("rstx_pad_o", 64'(pad_o), 64'(1));
    check("rstx_tx_col", 64'(tx_col), 64'(0));
    check("rstx_rx_data", 64'(rx_data), 64'(0));
    check("rstx_ready", 64'(tx_ready), 64'(0));
    rst = 1'b0;
    #1;
    check("rstx_idle_ready", 64'(tx_ready), 64'(1));
    tick(3);
    check("rstx_no_col", 64'(cnt_col - col0), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sing_wire_xcvr.md
Name: sing_wire_xcvr

Overview:
- Half-duplex, single-wire, bit-serial transceiver that sits directly upstream of a bidirectional pad buffer (IOBUF).
- Drives the buffer's data input (pad_o) and tristate control (pad_t), and consumes its pad output (pad_i).
- Lets a feature test move bytes both ways over one shared pin (e.g. jc1) with a defined bus turnaround and collision detection.
- Line idles high through the board pull-up whenever nobody drives it.

Parameters:
- DATA_W, 8: payload bits per frame.
- BIT_CYC, 4: clk cycles per bit. Must be even and >= 4.
- TURN_CYC, 2: clk cycles the line stays released after any TX frame or abort.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- tx_valid  in  1  TX byte offered
- tx_ready  out  1  TX byte accepted when tx_valid && tx_ready
- tx_data  in  DATA_W  TX payload
- tx_col  out  1  one-cycle pulse: collision detected, frame aborted
- rx_valid  out  1  one-cycle pulse: rx_data holds a good frame
- rx_data  out  DATA_W  last good RX payload, held until the next good frame
- rx_err  out  1  one-cycle pulse: stop bit sampled 0, frame dropped
- pad_o  out  1  to IOBUF I
- pad_t  out  1  to IOBUF T (1 = released / hi-Z)
- pad_i  in  1  from IOBUF O

Behaviour:
- Frame format:
  - Start bit 0, then DATA_W bits LSB-first, then stop bit 1.
  - Each bit lasts BIT_CYC cycles.
- Input path:
  - pad_i passes through a 2-FF synchronizer reset to 1, giving ps.
  - fall = ps_prev & ~ps.
- Reset values: pad_t=1, pad_o=1, tx_col=0, rx_valid=0, rx_err=0, rx_data=0, state=IDLE.
- tx_ready:
  - Combinational: (state==IDLE) && !fall && !rst.
  - When fall and tx_valid coincide, RX wins and the TX byte is not accepted.
- IDLE:
  - On accept, latch tx_data and go to TX. From the next cycle, pad_t=0 and pad_o=0.
  - Else, on fall, go to RX with bit counter 0 and cycle counter 0.
- TX:
  - Drives start, data, stop, each for BIT_CYC cycles. Total (DATA_W+2)*BIT_CYC cycles with pad_t=0.
  - Collision check: at cycle BIT_CYC-1 of each bit (synchronizer latency covered), if pad_o==1 and ps==0, then:
    - pulse tx_col;
    - next cycle pad_t=1, pad_o=1;
    - go to TURN.
  - Normal end: after the last stop-bit cycle, pad_t=1 and go to TURN.
- TURN:
  - pad_t=1 for exactly TURN_CYC cycles, then IDLE.
  - fall is ignored in TURN.
- RX:
  - pad_t stays 1. Sample ps at cycle BIT_CYC/2-1 of each bit period, measured from the fall cycle.
  - Start-bit sample ==1 is a glitch: back to IDLE with no pulses.
  - Data samples shift in LSB-first.
  - Stop sample ==1: rx_data updates and rx_valid pulses on the cycle after the stop sample.
  - Stop sample ==0: rx_err pulses and rx_data is unchanged.
  - Either way, then IDLE. No turnaround after RX.
- Counters:
  - Cycle counter width $clog2(BIT_CYC); wraps at BIT_CYC-1.
  - Bit counter width $clog2(DATA_W+2).
- rst asserted mid-frame:
  - Next edge returns all outputs to reset values and releases the line immediately.
  - No pulses are emitted for the aborted frame.
- rx_valid, rx_err and tx_col are mutually exclusive, and none can occur in the same cycle as an accept.

Decomposition:
- Shared package sing_wire_pkg holds:
  - state enum {IDLE, TX, TURN, RX};
  - frame constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1;
  - function frame_cycles(DATA_W, BIT_CYC).
- One sub-module: sing_wire_sync, the 2-FF synchronizer plus falling-edge detector, reset to 1.

Test Plan (DATA_W=8, BIT_CYC=4, TURN_CYC=2; bench models the IOBUF with a pull-up and an external driver):
- TX 8'hA5 with no external driver:
  - pad_t=0 for exactly 40 cycles;
  - pad_o sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles;
  - then pad_t=1 for 2 cycles, then tx_ready=1.
- External driver sends frame 8'h3C:
  - rx_valid pulses once, rx_data=8'h3C, rx_err=0;
  - pad_t stays 1 throughout.
- External 2-cycle low glitch on an idle line: no rx_valid, no rx_err; tx_ready returns to 1 within 4 cycles of the glitch.
- External frame with stop bit held 0: rx_err pulses once, no rx_valid, rx_data keeps the previous value 8'h3C.
- External driver pulls the line low during a TX '1' data bit of 8'hFF:
  - tx_col pulses;
  - the cycle after, pad_t=1;
  - the line stays released for 2 cycles, then IDLE.
- tx_valid=1 in the same cycle as an external falling edge:
  - tx_ready=0 and the byte is not accepted;
  - the RX frame completes;
  - the TX byte is accepted on the first IDLE cycle after rx_valid.
- rst pulse mid-TX: pad_t=1 and pad_o=1 on the next cycle, no tx_col.
